// File: rtl/rx_buffer_pkg.sv
// Shared constants and types for the RX slot buffer write path.
package rx_buffer_pkg;

    localparam int unsigned els_lp        = 2048;
    localparam int unsigned addr_width_lp = 11;
    localparam int unsigned size_width_lp = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } rx_writer_state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [size_width_lp-1:0] sat_inc(input logic [size_width_lp-1:0] v);
        return (v == {size_width_lp{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rx_byte_packer.sv
// Byte-lane accumulator: collects bytes into a buffer-width word and emits it
// when the top lane fills or the frame ends. Unfilled lanes of a flushed word are 0.
module rx_byte_packer #(
    parameter int data_width_p = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    byte_v_i,
    input  logic [7:0]              byte_i,
    input  logic                    last_i,
    input  logic                    clear_i,
    output logic                    word_v_o,
    output logic [data_width_p-1:0] word_o
);

    localparam int bytes_lp  = data_width_p / 8;
    localparam int lane_w_lp = $clog2(bytes_lp);
    localparam logic [lane_w_lp-1:0] top_lane_lp = lane_w_lp'(bytes_lp - 1);

    logic [lane_w_lp-1:0]    r_lane;
    logic [data_width_p-1:0] r_pack;
    logic [data_width_p-1:0] r_word;
    logic                    r_word_v;
    logic [data_width_p-1:0] w_merged;
    logic                    w_emit;

    // Current pack register with the incoming byte dropped into its lane.
    always_comb begin
        w_merged = r_pack;
        w_merged[{r_lane, 3'b000} +: 8] = byte_i;
    end

    assign w_emit = byte_v_i & (last_i | (r_lane == top_lane_lp));

    // Lane/pack state advance and registered word output.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_lane   <= '0;
            r_pack   <= '0;
            r_word   <= '0;
            r_word_v <= 1'b0;
        end else begin
            r_word_v <= w_emit;
            if (w_emit) begin
                r_word <= w_merged;
            end
            if (clear_i || w_emit) begin
                r_lane <= '0;
                r_pack <= '0;
            end else if (byte_v_i) begin
                r_lane <= r_lane + 1'b1;
                r_pack <= w_merged;
            end
        end
    end

    assign word_v_o = r_word_v;
    assign word_o   = r_word;

endmodule

// File: rtl/rx_frame_writer.sv
// Packs the MAC RX byte stream into buffer words, writes them at aligned slot
// addresses and commits good frames; errored, oversize or slot-less frames are
// dropped since the MAC cannot be stalled.
module rx_frame_writer
    import rx_buffer_pkg::*;
#(
    parameter int data_width_p      = 64,
    parameter int max_frame_bytes_p = 2048
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     rx_v_i,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_last_i,
    input  logic                     rx_error_i,
    output logic                     write_slot_v_o,
    input  logic                     write_slot_ready_and_i,
    output logic                     write_size_v_o,
    output logic [size_width_lp-1:0] write_size_o,
    output logic                     write_v_o,
    output logic [addr_width_lp-1:0] write_addr_o,
    output logic [data_width_p-1:0]  write_data_o,
    output logic                     drop_v_o,
    output logic [size_width_lp-1:0] drop_count_o
);

    localparam int bytes_lp = data_width_p / 8;
    // A frame can never be allowed to run past the end of its slot.
    localparam logic [size_width_lp-1:0] max_lp =
        (max_frame_bytes_p > els_lp) ? size_width_lp'(els_lp) : size_width_lp'(max_frame_bytes_p);
    localparam logic [addr_width_lp-1:0] addr_mask_lp = addr_width_lp'(bytes_lp - 1);

    rx_writer_state_e         r_state;
    rx_writer_state_e         w_state_nxt;
    logic [size_width_lp-1:0] r_count;
    logic [addr_width_lp-1:0] r_addr;
    logic [size_width_lp-1:0] r_size;
    logic                     r_commit;
    logic                     r_drop_v;
    logic [size_width_lp-1:0] r_drop_cnt;
    logic                     w_slot_ok;
    logic                     w_accept;
    logic                     w_clear;
    logic                     w_commit;
    logic                     w_drop;

    // A commit in flight still owns the free slot this cycle, so a new start must not claim it.
    assign w_slot_ok = write_slot_ready_and_i & ~r_commit;

    // Next-state and per-byte decisions: accept into the packer, commit or drop.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_clear     = 1'b0;
        w_commit    = 1'b0;
        w_drop      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (rx_v_i) begin
                    if (w_slot_ok) begin
                        w_accept = 1'b1;
                        if (rx_last_i) begin
                            w_commit = ~rx_error_i;
                            w_drop   = rx_error_i;
                        end else begin
                            w_state_nxt = RECV;
                        end
                    end else if (rx_last_i) begin
                        w_drop = 1'b1;
                    end else begin
                        w_state_nxt = DROP;
                    end
                end
            end
            RECV: begin
                if (rx_v_i) begin
                    if (r_count == max_lp) begin
                        // Oversize: this byte is discarded and any partial lanes are abandoned.
                        w_clear = 1'b1;
                        if (rx_last_i) begin
                            w_drop      = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = DROP;
                        end
                    end else begin
                        w_accept = 1'b1;
                        if (rx_last_i) begin
                            w_commit    = ~rx_error_i;
                            w_drop      = rx_error_i;
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            DROP: begin
                if (rx_v_i && rx_last_i) begin
                    w_drop      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, byte count and word address tracking.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_count <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == RECV) begin
                if (w_accept) begin
                    r_count <= r_count + 1'b1;
                end
            end else begin
                r_count <= '0;
            end
            if (w_accept) begin
                r_addr <= r_count[addr_width_lp-1:0] & ~addr_mask_lp;
            end
        end
    end

    // Commit, size and drop reporting.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_commit   <= 1'b0;
            r_size     <= '0;
            r_drop_v   <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_commit <= w_commit;
            r_drop_v <= w_drop;
            if (w_commit) begin
                r_size <= r_count + 1'b1;
            end
            if (w_drop) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    rx_byte_packer #(
        .data_width_p (data_width_p)
    ) u_packer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .byte_v_i  (w_accept),
        .byte_i    (rx_data_i),
        .last_i    (rx_last_i),
        .clear_i   (w_clear),
        .word_v_o  (write_v_o),
        .word_o    (write_data_o)
    );

    assign write_addr_o   = r_addr;
    assign write_slot_v_o = r_commit;
    assign write_size_v_o = r_commit;
    assign write_size_o   = r_size;
    assign drop_v_o       = r_drop_v;
    assign drop_count_o   = r_drop_cnt;

endmodule

// File: tb/tb_rx_frame_writer.sv
// Directed bench for rx_frame_writer at 64-bit word width.
module tb_rx_frame_writer;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rx_v, rx_last, rx_err, ready;
    logic [7:0]    rx_data;
    logic          slot_v, size_v, wr_v, drop_v;
    logic [15:0]   size, drop_cnt;
    logic [10:0]   wr_addr;
    logic [DW-1:0] wr_data;

    rx_frame_writer #(.data_width_p(DW), .max_frame_bytes_p(2048)) dut (
        .clk_i                  (clk),
        .reset_n_i              (reset_n),
        .rx_v_i                 (rx_v),
        .rx_data_i              (rx_data),
        .rx_last_i              (rx_last),
        .rx_error_i             (rx_err),
        .write_slot_v_o         (slot_v),
        .write_slot_ready_and_i (ready),
        .write_size_v_o         (size_v),
        .write_size_o           (size),
        .write_v_o              (wr_v),
        .write_addr_o           (wr_addr),
        .write_data_o           (wr_data),
        .drop_v_o               (drop_v),
        .drop_count_o           (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int k, input int seed);
        return 8'((k * 7 + seed * 13 + 1) & 255);
    endfunction

    function automatic logic [63:0] exp_word(input int seed, input int len, input int w);
        logic [63:0] r;
        r = '0;
        for (int lane = 0; lane < 8; lane++) begin
            if (w * 8 + lane < len) r[lane*8 +: 8] = pat(w * 8 + lane, seed);
        end
        return r;
    endfunction

    // Output monitor, sampled on the falling edge.
    logic [10:0] m_addr [1024];
    logic [63:0] m_data [1024];
    int          m_cyc  [1024];
    int n_wr = 0, n_commit = 0, n_drop = 0, n_both = 0, n_sizev = 0;
    int last_size = 0, commit_cyc = 0;

    always @(negedge clk) begin
        if (wr_v) begin
            if (n_wr < 1024) begin
                m_addr[n_wr] = wr_addr;
                m_data[n_wr] = wr_data;
                m_cyc[n_wr]  = cyc;
            end
            n_wr++;
        end
        if (slot_v) begin
            n_commit++;
            last_size  = size;
            commit_cyc = cyc;
        end
        if (drop_v) n_drop++;
        if (drop_v && slot_v) n_both++;
        if (size_v != slot_v) n_sizev++;
    end

    int byte_cyc [2100];

    task automatic send_frame(input int len, input int seed, input bit err, input bit rdy0, input int gap_every);
        for (int k = 0; k < len; k++) begin
            if (gap_every > 0 && k > 0 && (k % gap_every) == 0) begin
                @(negedge clk);
                rx_v = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
            end
            @(negedge clk);
            rx_v        = 1'b1;
            rx_data     = pat(k, seed);
            rx_last     = (k == len - 1);
            rx_err      = err && (k == len - 1);
            ready       = (k == 0) ? rdy0 : 1'b1;
            byte_cyc[k] = cyc;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_v = 1'b0; rx_last = 1'b0; rx_err = 1'b0; ready = 1'b1;
        repeat (n) @(negedge clk);
        #1;
    endtask

    int bw, bc, bd;

    initial begin
        reset_n = 1'b0; rx_v = 1'b0; rx_data = 8'h00; rx_last = 1'b0; rx_err = 1'b0; ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_wr_v", wr_v, 0);
        check("rst_slot_v", slot_v, 0);
        check("rst_size_v", size_v, 0);
        check("rst_size", size, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        check("rst_drop_v", drop_v, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // 64-byte good frame
        bw = n_wr; bc = n_commit; bd = n_drop;
        send_frame(64, 1, 1'b0, 1'b1, 0);
        idle(3);
        check("t1_nwr", n_wr - bw, 8);
        for (int w = 0; w < 8; w++) begin
            check($sformatf("t1_addr%0d", w), m_addr[bw + w], 64'(w * 8));
            check($sformatf("t1_data%0d", w), m_data[bw + w], exp_word(1, 64, w));
            check($sformatf("t1_lat%0d", w), m_cyc[bw + w] - byte_cyc[8 * w + 7], 1);
        end
        check("t1_commit", n_commit - bc, 1);
        check("t1_size", last_size, 64);
        check("t1_commit_lat", commit_cyc - byte_cyc[63], 1);
        check("t1_drops", n_drop - bd, 0);

        // 13-byte good frame with mid-frame valid gaps
        bw = n_wr; bc = n_commit;
        send_frame(13, 2, 1'b0, 1'b1, 3);
        idle(3);
        check("t2_nwr", n_wr - bw, 2);
        check("t2_addr0", m_addr[bw], 0);
        check("t2_addr1", m_addr[bw + 1], 8);
        check("t2_data0", m_data[bw], exp_word(2, 13, 0));
        check("t2_data1", m_data[bw + 1], exp_word(2, 13, 1));
        check("t2_pad", m_data[bw + 1] >> 40, 0);
        check("t2_commit", n_commit - bc, 1);
        check("t2_size", last_size, 13);

        // single-byte frame, then a frame starting in the commit cycle
        bw = n_wr; bc = n_commit; bd = n_drop;
        send_frame(1, 3, 1'b0, 1'b1, 0);
        send_frame(4, 4, 1'b0, 1'b1, 0);
        idle(3);
        check("t3_nwr", n_wr - bw, 1);
        check("t3_data", m_data[bw], {56'h0, pat(0, 3)});
        check("t3_commit", n_commit - bc, 1);
        check("t3_size", last_size, 1);
        check("t3_drop", n_drop - bd, 1);
        check("t3_drop_cnt", drop_cnt, 1);

        // 100-byte errored frame
        bw = n_wr; bc = n_commit; bd = n_drop;
        send_frame(100, 5, 1'b1, 1'b1, 0);
        idle(3);
        check("t4_nwr", n_wr - bw, 13);
        check("t4_commit", n_commit - bc, 0);
        check("t4_drop", n_drop - bd, 1);
        check("t4_drop_cnt", drop_cnt, 2);

        // no free slot at the first byte, then a normal frame
        bw = n_wr; bc = n_commit; bd = n_drop;
        send_frame(60, 6, 1'b0, 1'b0, 0);
        idle(3);
        check("t5_nwr", n_wr - bw, 0);
        check("t5_commit", n_commit - bc, 0);
        check("t5_drop_cnt", drop_cnt, 3);
        bw = n_wr; bc = n_commit;
        send_frame(20, 7, 1'b0, 1'b1, 0);
        idle(3);
        check("t5b_nwr", n_wr - bw, 3);
        check("t5b_commit", n_commit - bc, 1);
        check("t5b_size", last_size, 20);

        // oversize frame then a maximum-size frame
        bw = n_wr; bc = n_commit; bd = n_drop;
        send_frame(2049, 8, 1'b0, 1'b1, 0);
        idle(3);
        check("t6_nwr", n_wr - bw, 256);
        check("t6_last_addr", m_addr[bw + 255], 2040);
        check("t6_commit", n_commit - bc, 0);
        check("t6_drop", n_drop - bd, 1);
        check("t6_drop_cnt", drop_cnt, 4);
        bw = n_wr; bc = n_commit;
        send_frame(2048, 9, 1'b0, 1'b1, 0);
        idle(3);
        check("t6b_nwr", n_wr - bw, 256);
        check("t6b_last_data", m_data[bw + 255], exp_word(9, 2048, 255));
        check("t6b_commit", n_commit - bc, 1);
        check("t6b_size", last_size, 2048);

        // reset mid-frame
        send_frame(30, 10, 1'b0, 1'b1, 0);
        @(negedge clk);
        reset_n = 1'b0; rx_v = 1'b0; rx_last = 1'b0;
        #1;
        check("t7_rst_data", wr_data, 0);
        check("t7_rst_addr", wr_addr, 0);
        check("t7_rst_drop_cnt", drop_cnt, 0);
        check("t7_rst_wr_v", wr_v, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        bw = n_wr; bc = n_commit;
        send_frame(16, 11, 1'b0, 1'b1, 0);
        idle(3);
        check("t7_nwr", n_wr - bw, 2);
        check("t7_addr0", m_addr[bw], 0);
        check("t7_data1", m_data[bw + 1], exp_word(11, 16, 1));
        check("t7_size", last_size, 16);
        check("t7_commit", n_commit - bc, 1);

        check("never_both", n_both, 0);
        check("size_v_tracks_slot_v", n_sizev, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
